// File: rtl/reg_cmd_decoder.sv
// Byte-stream command decoder: frames from a UART RX path become register-file
// writes/reads and ALU start pulses. One command in flight; every output is registered.
module reg_cmd_decoder #(
    parameter int               WIDTH   = 8,
    parameter int               ADDR    = 4,
    parameter int               TIMEOUT = 1024,
    parameter logic [WIDTH-1:0] CMD_WR  = 8'hAA,
    parameter logic [WIDTH-1:0] CMD_RD  = 8'hBB,
    parameter logic [WIDTH-1:0] CMD_ALU = 8'hCC
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] RX_DATA,
    input  logic             RX_VLD,
    input  logic [WIDTH-1:0] RdData,
    output logic             WrEn,
    output logic             RdEn,
    output logic [ADDR-1:0]  Address,
    output logic [WIDTH-1:0] WrData,
    output logic             CONTROL_EN,
    output logic [WIDTH-1:0] RD_OUT,
    output logic             RD_OUT_VLD,
    output logic             BUSY,
    output logic             FRM_ERR
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_W_ADDR, S_W_DATA, S_R_ADDR, S_A_OPA, S_A_OPB,
        S_WR_EXEC, S_RD_EXEC, S_RD_WAIT, S_RD_CAP, S_ALU_WA, S_ALU_WB, S_ALU_GO
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [ADDR-1:0]  r_addr, w_addr_nxt;
    logic [WIDTH-1:0] r_opa, w_opa_nxt;
    logic [WIDTH-1:0] r_opb, w_opb_nxt;
    logic             r_wr_en, w_wr_en;
    logic             r_rd_en, w_rd_en;
    logic [ADDR-1:0]  r_address, w_address;
    logic [WIDTH-1:0] r_wr_data, w_wr_data;
    logic             r_ctrl_en, w_ctrl_en;
    logic [WIDTH-1:0] r_rd_out, w_rd_out;
    logic             r_rd_vld, w_rd_vld;
    logic             r_frm_err, w_frm_err;
    logic             w_addr_ok;
    logic             w_tmo;

    assign w_addr_ok = (RX_DATA[WIDTH-1:ADDR] == '0);
    assign w_tmo     = (r_cnt == CW'(TIMEOUT - 1));

    // Next-state and next-output decode; idle frame states share the timeout branch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_addr_nxt  = r_addr;
        w_opa_nxt   = r_opa;
        w_opb_nxt   = r_opb;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        w_address   = r_address;
        w_wr_data   = r_wr_data;
        w_ctrl_en   = 1'b0;
        w_rd_out    = r_rd_out;
        w_rd_vld    = 1'b0;
        w_frm_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (RX_VLD && RX_DATA == CMD_WR) begin
                    w_state_nxt = S_W_ADDR;
                end else if (RX_VLD && RX_DATA == CMD_RD) begin
                    w_state_nxt = S_R_ADDR;
                end else if (RX_VLD && RX_DATA == CMD_ALU) begin
                    w_state_nxt = S_A_OPA;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_W_ADDR, S_R_ADDR: begin
                if (RX_VLD && !w_addr_ok) begin
                    w_state_nxt = S_IDLE;
                    w_frm_err   = 1'b1;
                end else if (RX_VLD && r_state == S_W_ADDR) begin
                    w_addr_nxt  = RX_DATA[ADDR-1:0];
                    w_state_nxt = S_W_DATA;
                end else if (RX_VLD) begin
                    w_rd_en     = 1'b1;
                    w_address   = RX_DATA[ADDR-1:0];
                    w_state_nxt = S_RD_EXEC;
                end else if (w_tmo) begin
                    w_state_nxt = S_IDLE;
                    w_frm_err   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_W_DATA, S_A_OPA, S_A_OPB: begin
                if (RX_VLD && r_state == S_W_DATA) begin
                    w_wr_en     = 1'b1;
                    w_address   = r_addr;
                    w_wr_data   = RX_DATA;
                    w_state_nxt = S_WR_EXEC;
                end else if (RX_VLD && r_state == S_A_OPA) begin
                    w_opa_nxt   = RX_DATA;
                    w_state_nxt = S_A_OPB;
                end else if (RX_VLD) begin
                    w_opb_nxt   = RX_DATA;
                    w_wr_en     = 1'b1;
                    w_address   = ADDR'(0);
                    w_wr_data   = r_opa;
                    w_state_nxt = S_ALU_WA;
                end else if (w_tmo) begin
                    w_state_nxt = S_IDLE;
                    w_frm_err   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            // Execution states run to completion; a byte arriving here is dropped and flagged.
            S_WR_EXEC: begin
                w_frm_err   = RX_VLD;
                w_state_nxt = S_IDLE;
            end
            S_RD_EXEC: begin
                w_frm_err   = RX_VLD;
                w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                w_frm_err   = RX_VLD;
                w_rd_out    = RdData;
                w_rd_vld    = 1'b1;
                w_state_nxt = S_RD_CAP;
            end
            S_RD_CAP: begin
                w_frm_err   = RX_VLD;
                w_state_nxt = S_IDLE;
            end
            S_ALU_WA: begin
                w_frm_err   = RX_VLD;
                w_wr_en     = 1'b1;
                w_address   = ADDR'(1);
                w_wr_data   = r_opb;
                w_state_nxt = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_frm_err   = RX_VLD;
                w_ctrl_en   = 1'b1;
                w_state_nxt = S_ALU_GO;
            end
            S_ALU_GO: begin
                w_frm_err   = RX_VLD;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, frame context and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_address <= '0;
            r_wr_data <= '0;
            r_ctrl_en <= 1'b0;
            r_rd_out  <= '0;
            r_rd_vld  <= 1'b0;
            r_frm_err <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_addr    <= w_addr_nxt;
            r_opa     <= w_opa_nxt;
            r_opb     <= w_opb_nxt;
            r_wr_en   <= w_wr_en;
            r_rd_en   <= w_rd_en;
            r_address <= w_address;
            r_wr_data <= w_wr_data;
            r_ctrl_en <= w_ctrl_en;
            r_rd_out  <= w_rd_out;
            r_rd_vld  <= w_rd_vld;
            r_frm_err <= w_frm_err;
            BUSY      <= (w_state_nxt != S_IDLE);
        end
    end

    assign WrEn       = r_wr_en;
    assign RdEn       = r_rd_en;
    assign Address    = r_address;
    assign WrData     = r_wr_data;
    assign CONTROL_EN = r_ctrl_en;
    assign RD_OUT     = r_rd_out;
    assign RD_OUT_VLD = r_rd_vld;
    assign FRM_ERR    = r_frm_err;

endmodule

// File: tb/tb_reg_cmd_decoder.sv
// Directed bench for reg_cmd_decoder with a small behavioural register file.
module tb_reg_cmd_decoder;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] RX_DATA = 8'h00;
    logic       RX_VLD = 1'b0;
    logic [7:0] RdData;
    logic       WrEn, RdEn, CONTROL_EN, RD_OUT_VLD, BUSY, FRM_ERR;
    logic [3:0] Address;
    logic [7:0] WrData, RD_OUT;

    int total = 0;
    int bad   = 0;

    logic [7:0] rf [0:15];

    reg_cmd_decoder dut (
        .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VLD(RX_VLD), .RdData(RdData),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .CONTROL_EN(CONTROL_EN), .RD_OUT(RD_OUT), .RD_OUT_VLD(RD_OUT_VLD),
        .BUSY(BUSY), .FRM_ERR(FRM_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (WrEn) rf[Address] <= WrData;
    end
    assign RdData = rf[Address];

    task automatic step(input logic v, input logic [7:0] d);
        RX_VLD  = v;
        RX_DATA = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        total++; if ({WrEn, RdEn, CONTROL_EN, RD_OUT_VLD, BUSY, FRM_ERR} !== 6'b0) begin bad++; $display("FAIL reset_strobes: got %b want 000000", {WrEn, RdEn, CONTROL_EN, RD_OUT_VLD, BUSY, FRM_ERR}); end
        total++; if (Address !== 4'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", Address); end
        total++; if (WrData !== 8'h00) begin bad++; $display("FAIL reset_wrdata: got %h want 00", WrData); end
        total++; if (RD_OUT !== 8'h00) begin bad++; $display("FAIL reset_rdout: got %h want 00", RD_OUT); end
        RST = 1'b0;
    endtask

    task automatic test_write();
        step(1'b1, 8'hAA);
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b want 1", BUSY); end
        step(1'b1, 8'h03);
        total++; if (WrEn !== 1'b0) begin bad++; $display("FAIL wr_early: got %b want 0", WrEn); end
        step(1'b1, 8'h5C);
        total++; if ({WrEn, RdEn, Address, WrData} !== {1'b1, 1'b0, 4'h3, 8'h5C}) begin bad++; $display("FAIL wr_exec: got en=%b rd=%b a=%h d=%h want en=1 rd=0 a=3 d=5c", WrEn, RdEn, Address, WrData); end
        step(1'b0, 8'h00);
        total++; if ({WrEn, BUSY} !== 2'b00) begin bad++; $display("FAIL wr_done: got en=%b busy=%b want 0 0", WrEn, BUSY); end
        total++; if ({Address, WrData} !== {4'h3, 8'h5C}) begin bad++; $display("FAIL wr_hold: got a=%h d=%h want a=3 d=5c", Address, WrData); end
        total++; if (rf[3] !== 8'h5C) begin bad++; $display("FAIL wr_rf: got %h want 5c", rf[3]); end
    endtask

    task automatic test_read();
        step(1'b1, 8'hAA); step(1'b1, 8'h02); step(1'b1, 8'h7E); step(1'b0, 8'h00);
        step(1'b1, 8'hBB);
        step(1'b1, 8'h02);
        total++; if ({RdEn, WrEn, Address} !== {1'b1, 1'b0, 4'h2}) begin bad++; $display("FAIL rd_exec: got rd=%b wr=%b a=%h want rd=1 wr=0 a=2", RdEn, WrEn, Address); end
        step(1'b0, 8'h00);
        total++; if ({RdEn, RD_OUT_VLD} !== 2'b00) begin bad++; $display("FAIL rd_wait: got rd=%b vld=%b want 0 0", RdEn, RD_OUT_VLD); end
        step(1'b0, 8'h00);
        total++; if ({RD_OUT_VLD, RD_OUT} !== {1'b1, 8'h7E}) begin bad++; $display("FAIL rd_cap: got vld=%b d=%h want vld=1 d=7e", RD_OUT_VLD, RD_OUT); end
        step(1'b0, 8'h00);
        total++; if ({RD_OUT_VLD, BUSY, RD_OUT} !== {2'b00, 8'h7E}) begin bad++; $display("FAIL rd_done: got vld=%b busy=%b d=%h want 0 0 7e", RD_OUT_VLD, BUSY, RD_OUT); end
    endtask

    task automatic test_alu();
        step(1'b1, 8'hCC); step(1'b1, 8'h12);
        step(1'b1, 8'h34);
        total++; if ({WrEn, Address, WrData, CONTROL_EN} !== {1'b1, 4'h0, 8'h12, 1'b0}) begin bad++; $display("FAIL alu_wa: got en=%b a=%h d=%h c=%b want 1 0 12 0", WrEn, Address, WrData, CONTROL_EN); end
        step(1'b0, 8'h00);
        total++; if ({WrEn, Address, WrData, CONTROL_EN} !== {1'b1, 4'h1, 8'h34, 1'b0}) begin bad++; $display("FAIL alu_wb: got en=%b a=%h d=%h c=%b want 1 1 34 0", WrEn, Address, WrData, CONTROL_EN); end
        step(1'b0, 8'h00);
        total++; if ({WrEn, CONTROL_EN} !== 2'b01) begin bad++; $display("FAIL alu_go: got en=%b c=%b want 0 1", WrEn, CONTROL_EN); end
        step(1'b0, 8'h00);
        total++; if ({CONTROL_EN, BUSY} !== 2'b00) begin bad++; $display("FAIL alu_done: got c=%b busy=%b want 0 0", CONTROL_EN, BUSY); end
    endtask

    task automatic test_bad_addr();
        step(1'b1, 8'h55);
        total++; if ({BUSY, FRM_ERR} !== 2'b00) begin bad++; $display("FAIL idle_junk: got busy=%b err=%b want 0 0", BUSY, FRM_ERR); end
        step(1'b1, 8'hAA);
        step(1'b1, 8'h13);
        total++; if ({FRM_ERR, WrEn, BUSY} !== 3'b100) begin bad++; $display("FAIL wr_badaddr: got err=%b en=%b busy=%b want 1 0 0", FRM_ERR, WrEn, BUSY); end
        step(1'b0, 8'h00);
        total++; if ({FRM_ERR, WrEn} !== 2'b00) begin bad++; $display("FAIL err_pulse: got err=%b en=%b want 0 0", FRM_ERR, WrEn); end
        step(1'b1, 8'hBB);
        step(1'b1, 8'hF2);
        total++; if ({FRM_ERR, RdEn, BUSY} !== 3'b100) begin bad++; $display("FAIL rd_badaddr: got err=%b rd=%b busy=%b want 1 0 0", FRM_ERR, RdEn, BUSY); end
        step(1'b0, 8'h00);
    endtask

    task automatic test_timeout();
        int errs;
        int drops;
        int wrs;
        errs = 0; drops = 0; wrs = 0;
        step(1'b1, 8'hAA);
        for (int i = 0; i < 1023; i++) begin
            step(1'b0, 8'h00);
            if (FRM_ERR) errs++;
            if (!BUSY) drops++;
        end
        total++; if (errs + drops !== 0) begin bad++; $display("FAIL tmo_alive: got err=%0d drop=%0d want 0 0", errs, drops); end
        step(1'b1, 8'h05);
        step(1'b1, 8'h66);
        total++; if ({WrEn, Address, WrData} !== {1'b1, 4'h5, 8'h66}) begin bad++; $display("FAIL tmo_edge_wr: got en=%b a=%h d=%h want 1 5 66", WrEn, Address, WrData); end
        step(1'b0, 8'h00);
        errs = 0;
        step(1'b1, 8'hAA);
        for (int i = 0; i < 1023; i++) begin
            step(1'b0, 8'h00);
            if (FRM_ERR) errs++;
            if (WrEn) wrs++;
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL tmo_early: got %0d want 0", errs); end
        step(1'b0, 8'h00);
        total++; if ({FRM_ERR, BUSY, WrEn} !== 3'b100) begin bad++; $display("FAIL tmo_abort: got err=%b busy=%b en=%b want 1 0 0", FRM_ERR, BUSY, WrEn); end
        step(1'b1, 8'h03);
        if (WrEn) wrs++;
        step(1'b1, 8'h44);
        if (WrEn) wrs++;
        total++; if ({wrs, FRM_ERR, BUSY} !== {32'd0, 2'b00}) begin bad++; $display("FAIL tmo_after: got wrs=%0d err=%b busy=%b want 0 0 0", wrs, FRM_ERR, BUSY); end
    endtask

    task automatic test_busy_err();
        step(1'b1, 8'hCC); step(1'b1, 8'h12); step(1'b1, 8'h34);
        step(1'b1, 8'h77);
        total++; if ({FRM_ERR, WrEn, Address, WrData} !== {2'b11, 4'h1, 8'h34}) begin bad++; $display("FAIL alu_rxerr: got err=%b en=%b a=%h d=%h want 1 1 1 34", FRM_ERR, WrEn, Address, WrData); end
        step(1'b0, 8'h00);
        total++; if ({CONTROL_EN, FRM_ERR} !== 2'b10) begin bad++; $display("FAIL alu_rxerr_go: got c=%b err=%b want 1 0", CONTROL_EN, FRM_ERR); end
        step(1'b0, 8'h00);
        step(1'b1, 8'hAA); step(1'b1, 8'h03);
        RST = 1'b1;
        step(1'b0, 8'h00);
        RST = 1'b0;
        total++; if ({WrEn, BUSY, FRM_ERR, Address} !== 7'b0) begin bad++; $display("FAIL rst_mid: got en=%b busy=%b err=%b a=%h want 0 0 0 0", WrEn, BUSY, FRM_ERR, Address); end
        step(1'b1, 8'h5A);
        total++; if ({WrEn, BUSY} !== 2'b00) begin bad++; $display("FAIL rst_discard: got en=%b busy=%b want 0 0", WrEn, BUSY); end
        step(1'b1, 8'hAA); step(1'b1, 8'h04);
        step(1'b1, 8'h01);
        total++; if ({WrEn, Address, WrData} !== {1'b1, 4'h4, 8'h01}) begin bad++; $display("FAIL rst_recover: got en=%b a=%h d=%h want 1 4 01", WrEn, Address, WrData); end
        step(1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        step(1'b1, 8'hAA); step(1'b1, 8'h0B);
        step(1'b1, 8'hBB);
        total++; if ({WrEn, Address, WrData} !== {1'b1, 4'hB, 8'hBB}) begin bad++; $display("FAIL opc_as_data: got en=%b a=%h d=%h want 1 b bb", WrEn, Address, WrData); end
        step(1'b1, 8'hBB);
        total++; if ({FRM_ERR, BUSY} !== 2'b10) begin bad++; $display("FAIL exec_rx: got err=%b busy=%b want 1 0", FRM_ERR, BUSY); end
        step(1'b1, 8'hBB);
        total++; if ({BUSY, FRM_ERR} !== 2'b10) begin bad++; $display("FAIL b2b_opcode: got busy=%b err=%b want 1 0", BUSY, FRM_ERR); end
        step(1'b1, 8'h0B);
        total++; if ({RdEn, WrEn, Address} !== {2'b10, 4'hB}) begin bad++; $display("FAIL b2b_rd: got rd=%b wr=%b a=%h want 1 0 b", RdEn, WrEn, Address); end
        step(1'b0, 8'h00);
        step(1'b1, 8'hCC);
        total++; if ({RD_OUT_VLD, RD_OUT, FRM_ERR} !== {1'b1, 8'hBB, 1'b1}) begin bad++; $display("FAIL b2b_cap: got vld=%b d=%h err=%b want 1 bb 1", RD_OUT_VLD, RD_OUT, FRM_ERR); end
        step(1'b0, 8'h00);
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", BUSY); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_alu();
        test_bad_addr();
        test_timeout();
        test_busy_err();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
